// File: rtl/issue_queue_if.sv
// Fetch-side and issue-side signals of the instruction issue queue.
// The master is the fetch/check environment; the slave is the queue.
interface issue_queue_if #(
  parameter int DEPTH = 8,
  parameter int PCW   = 13,
  parameter int IW    = 32
);
  logic                     flush;
  logic [1:0]               f_valid;
  logic [PCW-1:0]           f_pc1;
  logic [PCW-1:0]           f_pc2;
  logic [IW-1:0]            f_inst1;
  logic [IW-1:0]            f_inst2;
  logic                     f_ready;
  logic [PCW-1:0]           pc1_out;
  logic [PCW-1:0]           pc2_out;
  logic [IW-1:0]            inst1_out;
  logic [IW-1:0]            inst2_out;
  logic [1:0]               out_count;
  logic [1:0]               consume;
  logic [$clog2(DEPTH):0]   occupancy;

  modport master (
    output flush, f_valid, f_pc1, f_pc2, f_inst1, f_inst2, consume,
    input  f_ready, pc1_out, pc2_out, inst1_out, inst2_out, out_count, occupancy
  );

  modport slave (
    input  flush, f_valid, f_pc1, f_pc2, f_inst1, f_inst2, consume,
    output f_ready, pc1_out, pc2_out, inst1_out, inst2_out, out_count, occupancy
  );
endinterface

// File: rtl/issue_queue.sv
// Circular two-in / two-out instruction queue between fetch and the dual-issue check stage.
// Outputs read registered state directly; empty slots present as 0 (NOP).
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int PCW   = 13,
  parameter int IW    = 32
) (
  input logic         CLK,
  input logic         RST,
  issue_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PCW + IW;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [1:0]    push_n;
  logic [1:0]    pop_n;
  logic [1:0]    out_cnt;
  logic          ready;
  logic [EW-1:0] ent1, ent2;

  always_comb begin
    ready   = (count_q <= CW'(DEPTH - 2));
    out_cnt = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];

    push_n = 2'd0;
    if (ready && !q.flush) begin
      case (q.f_valid)
        2'b01:   push_n = 2'd1;
        2'b11:   push_n = 2'd2;
        default: push_n = 2'd0;  // 2'b10 is illegal and dropped
      endcase
    end

    pop_n = (q.consume > out_cnt) ? out_cnt : q.consume;

    mem_d = mem_q;
    if (push_n != 2'd0) mem_d[wr_ptr_q] = {q.f_pc1, q.f_inst1};
    if (push_n == 2'd2) mem_d[wr_ptr_q + AW'(1)] = {q.f_pc2, q.f_inst2};

    rd_ptr_d = rd_ptr_q + AW'(pop_n);
    wr_ptr_d = wr_ptr_q + AW'(push_n);
    count_d  = count_q + CW'(push_n) - CW'(pop_n);

    if (q.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; count gates every read.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  always_comb begin
    ent1 = (count_q >= CW'(1)) ? mem_q[rd_ptr_q]          : '0;
    ent2 = (count_q >= CW'(2)) ? mem_q[rd_ptr_q + AW'(1)] : '0;
  end

  assign q.f_ready   = ready;
  assign q.out_count = out_cnt;
  assign q.occupancy = count_q;
  assign q.pc1_out   = ent1[EW-1:IW];
  assign q.inst1_out = ent1[IW-1:0];
  assign q.pc2_out   = ent2[EW-1:IW];
  assign q.inst2_out = ent2[IW-1:0];
endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Circular instruction queue between the two-wide fetch stage and the dual-issue pairing/check stage.
- Accepts up to two (pc, inst) pairs per cycle from fetch.
- Presents the two oldest entries to the check stage, which retires 0, 1 or 2 of them per cycle. The count depends on stall and on whether the pair was split for a dependency.
- Flushed on branch misprediction; applies backpressure to fetch.

Parameters:
DEPTH, 8, entry count; power of two, >= 4
PCW, 13, PC width
IW, 32, instruction width

Ports:
CLK  input  1  clock; all state changes on posedge
RST  input  1  synchronous reset, active-high
flush  input  1  misprediction flush (fail_predict), synchronous
f_valid  input  2  bit0: slot1 valid, bit1: slot2 valid; 2'b10 is illegal
f_pc1  input  PCW  pc of first fetched instruction
f_pc2  input  PCW  pc of second fetched instruction
f_inst1  input  IW  first fetched instruction
f_inst2  input  IW  second fetched instruction
f_ready  output  1  queue can accept two entries this cycle
pc1_out  output  PCW  pc of oldest entry
pc2_out  output  PCW  pc of second-oldest entry
inst1_out  output  IW  oldest instruction
inst2_out  output  IW  second-oldest instruction
out_count  output  2  valid entries presented: 0, 1 or 2
consume  input  2  entries retired by check stage this cycle (0..2)
occupancy  output  log2(DEPTH)+1  current entry count

Behaviour:
- State: storage array mem[DEPTH] of {pc, inst}; rd_ptr and wr_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH; count, log2(DEPTH)+1 bits.
- Reset (RST=1 at posedge): rd_ptr=0, wr_ptr=0, count=0. Array contents are not reset.
  - Resulting outputs: out_count=0, occupancy=0, f_ready=1, all pc/inst outputs 0.
- f_ready = (DEPTH - count >= 2). Combinational from count; independent of consume in the same cycle. No bypass-on-pop.
- Push count p:
  - p = 0 if !f_ready.
  - Otherwise f_valid 2'b00 -> 0, 2'b01 -> 1, 2'b11 -> 2, 2'b10 -> 0 (ignored).
- Push writes: slot1 goes to mem[wr_ptr]; slot2 (if p=2) goes to mem[wr_ptr+1 mod DEPTH]. wr_ptr += p.
- Pop count c = min(consume, out_count). Over-consume is clipped, never underflows. rd_ptr += c.
- count_next = count + p - c. Simultaneous push and pop is legal in every state, including a full queue (p=0 there because f_ready=0).
- Outputs are combinational from registered state (zero-latency read):
  - inst1_out/pc1_out = mem[rd_ptr] if count>=1, else 0.
  - inst2_out/pc2_out = mem[rd_ptr+1 mod DEPTH] if count>=2, else 0. The value 0 is the NOP used by the check stage.
  - out_count = min(count, 2). occupancy = count.
- Latency: an entry pushed at posedge N is visible on the outputs after posedge N. Minimum fetch-to-issue latency is 1 cycle; no fall-through.
- Ordering: strict FIFO. Slot1 of a push is always older than slot2.
- flush=1 at posedge: rd_ptr=0, wr_ptr=0, count=0. Flush overrides push and pop in the same cycle; the fetch data in that cycle is dropped.
- Priority: RST > flush > normal operation.
- Stall is expressed by the consumer as consume=0. The queue holds its outputs stable while count is unchanged and fetch is still free to fill it.
- Wrap-around: a two-entry push at wr_ptr=DEPTH-1 writes mem[DEPTH-1] and mem[0].
- Partial fetch (f_valid=2'b01) is used when the fetch target is the second slot of a line. It keeps ordering intact.

Test Plan:
- Reset, then push f_valid=11 with pc 0x000/0x004, inst 0x00500093/0x00A00113, consume=0 -> next cycle: out_count=2, pc1_out=0x000, inst2_out=0x00A00113, occupancy=2.
- Fill DEPTH=8 with four 2-pushes, consume=0 -> occupancy=8, f_ready=0. Fifth push is ignored; occupancy stays 8 and outputs are unchanged.
- Dependency split: 4 entries (pc 0,4,8,C); consume=1 for one cycle, then consume=2 -> after first edge pc1_out=4, pc2_out=8; after second edge pc1_out=C, out_count=1, inst2_out=0.
- Wrap: rd_ptr=wr_ptr=7 with queue empty, push pc 0x100/0x104 -> both entries are read back in order, pc1_out=0x100 and pc2_out=0x104, across the index 7->0 boundary.
- Flush with count=5 while f_valid=11 and consume=2 -> next cycle: occupancy=0, out_count=0, outputs 0, f_ready=1; fetched pair not stored.
- Over-consume: count=1, consume=2 -> count=0 with no underflow. f_valid=10 -> no push, occupancy unchanged.
